// File: rtl/alu_pkg.sv
// Shared opcode, FSM state and instruction-field definitions for the ALU sequencer.
// Combinational only; no latency or backpressure of its own.
package alu_pkg;

    localparam logic [4:0] OP_NOP = 5'd0;
    localparam logic [4:0] OP_ADD = 5'd1;
    localparam logic [4:0] OP_SUB = 5'd2;
    localparam logic [4:0] OP_AND = 5'd3;
    localparam logic [4:0] OP_OR  = 5'd4;
    localparam logic [4:0] OP_XOR = 5'd5;
    localparam logic [4:0] OP_SRL = 5'd6;
    localparam logic [4:0] OP_SRA = 5'd7;
    localparam logic [4:0] OP_SLL = 5'd8;

    localparam int INSTR_W   = 16;
    localparam int OP_MSB    = 15;
    localparam int OP_LSB    = 11;
    localparam int RD_MSB    = 10;
    localparam int RD_LSB    = 8;
    localparam int RS_MSB    = 7;
    localparam int RS_LSB    = 5;
    localparam int IMM_BIT   = 4;
    localparam int IMM4_MSB  = 3;
    localparam int RT_MSB    = 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } seq_state_e;

    function automatic logic op_legal(input logic [4:0] op);
        return (op >= OP_ADD) && (op <= OP_SLL);
    endfunction

endpackage

// File: rtl/alu_regfile.sv
// Register file: two async read ports, one sync write port, r0 reads as zero.
// Reads are combinational, writes land on the next clock edge; never stalls.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int DATA_W   = 16,
    parameter int NUM_REGS = 8,
    parameter int ADDR_W   = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i
);

    logic [DATA_W-1:0] mem_q [NUM_REGS];

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i && (waddr_i != '0)) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/alu_op_sequencer.sv
// Decodes one instruction at a time, feeds registered operands to the ALU and writes back.
// Handshake to done_o is 3 cycles, one accept every 4; ready only in IDLE. ALU_SEQ_FLAGS_EN adds zero_o/neg_o.
module alu_op_sequencer
    import alu_pkg::*;
#(
    parameter int DATA_W     = 16,
    parameter int NUM_REGS   = 8,
    parameter int REG_ADDR_W = 3
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              instr_valid_i,
    output logic              instr_ready_o,
    input  logic [15:0]       instr_i,
    output logic [DATA_W-1:0] alu_a_o,
    output logic [DATA_W-1:0] alu_b_o,
    output logic [4:0]        alu_op_o,
    input  logic [DATA_W-1:0] alu_result_i,
    output logic              done_o,
    output logic [DATA_W-1:0] result_o,
`ifdef ALU_SEQ_FLAGS_EN
    output logic              zero_o,
    output logic              neg_o,
`endif
    output logic              err_o
);

    seq_state_e        state_q, state_d;
    logic [15:0]       instr_q, instr_d;
    logic [DATA_W-1:0] a_q, a_d;
    logic [DATA_W-1:0] b_q, b_d;
    logic [4:0]        op_q, op_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              err_q, err_d;
    logic              rf_we;
    logic [DATA_W-1:0] rdata_a, rdata_b;

    logic [4:0]            dec_op;
    logic [REG_ADDR_W-1:0] dec_rd, dec_rs, dec_rt;
    logic                  dec_imm;
    logic [3:0]            dec_imm4;

    assign dec_op   = instr_q[OP_MSB:OP_LSB];
    assign dec_rd   = instr_q[RD_MSB:RD_LSB];
    assign dec_rs   = instr_q[RS_MSB:RS_LSB];
    assign dec_imm  = instr_q[IMM_BIT];
    assign dec_imm4 = instr_q[IMM4_MSB:0];
    assign dec_rt   = instr_q[RT_MSB:0];

    alu_regfile #(
        .DATA_W   (DATA_W),
        .NUM_REGS (NUM_REGS),
        .ADDR_W   (REG_ADDR_W)
    ) u_regfile (
        .clk_i     (clk_i),
        .rst_ni    (rst_ni),
        .raddr_a_i (dec_rs),
        .rdata_a_o (rdata_a),
        .raddr_b_i (dec_rt),
        .rdata_b_o (rdata_b),
        .we_i      (rf_we),
        .waddr_i   (dec_rd),
        .wdata_i   (res_q)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            instr_q <= '0;
            a_q     <= '0;
            b_q     <= '0;
            op_q    <= OP_NOP;
            res_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            instr_q <= instr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            res_q   <= res_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        instr_d       = instr_q;
        a_d           = a_q;
        b_d           = b_q;
        op_d          = op_q;
        res_d         = res_q;
        err_d         = 1'b0;
        rf_we         = 1'b0;
        instr_ready_o = 1'b0;
        done_o        = 1'b0;
        case (state_q)
            ST_IDLE: begin
                instr_ready_o = 1'b1;
                if (instr_valid_i) begin
                    instr_d = instr_i;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (op_legal(dec_op)) begin
                    a_d     = rdata_a;
                    b_d     = dec_imm ? {{(DATA_W-4){1'b0}}, dec_imm4} : rdata_b;
                    op_d    = dec_op;
                    state_d = ST_EXEC;
                end else begin
                    err_d   = 1'b1;
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                // Opcode drops back to NOP as the result is captured, so the ALU only sees it here.
                res_d   = alu_result_i;
                op_d    = OP_NOP;
                state_d = ST_WB;
            end
            ST_WB: begin
                rf_we   = 1'b1;
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign alu_a_o  = a_q;
    assign alu_b_o  = b_q;
    assign alu_op_o = op_q;
    assign result_o = res_q;
    assign err_o    = err_q;

`ifdef ALU_SEQ_FLAGS_EN
    logic zero_q, neg_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            zero_q <= 1'b0;
            neg_q  <= 1'b0;
        end else if (state_q == ST_WB) begin
            zero_q <= (res_q == '0);
            neg_q  <= res_q[DATA_W-1];
        end
    end

    assign zero_o = zero_q;
    assign neg_o  = neg_q;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Directed bench: sequencer driving a behavioural 16-bit ALU, hand-computed results.
module tb_alu_op_sequencer;

    logic        clk;
    logic        rst_n;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] alu_a, alu_b, alu_res, result;
    logic [4:0]  alu_op;
    logic        done, err;

    int vectors;
    int miscompares;

    alu_op_sequencer dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .instr_valid_i (instr_valid),
        .instr_ready_o (instr_ready),
        .instr_i       (instr),
        .alu_a_o       (alu_a),
        .alu_b_o       (alu_b),
        .alu_op_o      (alu_op),
        .alu_result_i  (alu_res),
        .done_o        (done),
        .result_o      (result),
        .err_o         (err)
    );

    always_comb begin
        alu_res = 16'h0000;
        case (alu_op)
            5'd1: alu_res = alu_a + alu_b;
            5'd2: alu_res = alu_a - alu_b;
            5'd3: alu_res = alu_a & alu_b;
            5'd4: alu_res = alu_a | alu_b;
            5'd5: alu_res = alu_a ^ alu_b;
            5'd6: alu_res = alu_a >> alu_b[3:0];
            5'd7: alu_res = $unsigned($signed(alu_a) >>> alu_b[3:0]);
            5'd8: alu_res = alu_a << alu_b[3:0];
            default: alu_res = 16'h0000;
        endcase
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] enc_i(input logic [4:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [3:0] imm4);
        return {op, rd, rs, 1'b1, imm4};
    endfunction

    function automatic logic [15:0] enc_r(input logic [4:0] op, input logic [2:0] rd,
                                          input logic [2:0] rs, input logic [2:0] rt);
        return {op, rd, rs, 1'b0, 1'b0, rt};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Called just after a falling edge with the sequencer idle; returns at a falling edge, idle again.
    task automatic run(input logic [15:0] ins, output logic [15:0] res, output int done_cyc,
                       output int err_cyc, output logic [4:0] op_c2, output logic [4:0] op_c3);
        res      = 16'hxxxx;
        done_cyc = -1;
        err_cyc  = -1;
        op_c2    = 5'h1f;
        op_c3    = 5'h1f;
        instr       = ins;
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c == 2) op_c2 = alu_op;
            if (c == 3) op_c3 = alu_op;
            if (done && done_cyc < 0) begin
                done_cyc = c;
                res      = result;
            end
            if (err && err_cyc < 0) err_cyc = c;
        end
    endtask

    task automatic expect_done(input string tag, input logic [15:0] ins, input logic [15:0] exp);
        logic [15:0] r;
        int dc, ec;
        logic [4:0] o2, o3;
        run(ins, r, dc, ec, o2, o3);
        check({tag, "_cyc"}, dc, 3);
        check({tag, "_res"}, {16'h0, r}, {16'h0, exp});
    endtask

    logic [15:0] r;
    int          dc, ec;
    logic [4:0]  o2, o3;
    logic [11:0] ready_mask, done_mask;
    logic [15:0] last_res;
    int          done_seen;

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        check("rst_ready", {31'h0, instr_ready}, 1);
        check("rst_done", {31'h0, done}, 0);
        check("rst_err", {31'h0, err}, 0);
        check("rst_result", {16'h0, result}, 0);
        check("rst_alu_a", {16'h0, alu_a}, 0);
        check("rst_alu_b", {16'h0, alu_b}, 0);
        check("rst_alu_op", {27'h0, alu_op}, 0);

        expect_done("add_r1", enc_i(5'd1, 3'd1, 3'd0, 4'd5), 16'd5);
        expect_done("add_r2", enc_i(5'd1, 3'd2, 3'd0, 4'd3), 16'd3);

        run(enc_r(5'd2, 3'd3, 3'd1, 3'd2), r, dc, ec, o2, o3);
        check("sub_r3_cyc", dc, 3);
        check("sub_r3_res", {16'h0, r}, 32'd2);
        check("sub_r3_op_exec", {27'h0, o2}, 32'd2);
        check("sub_r3_op_wb", {27'h0, o3}, 32'd0);
        check("sub_r3_a_hold", {16'h0, alu_a}, 32'd5);
        check("sub_r3_b_hold", {16'h0, alu_b}, 32'd3);
        expect_done("read_r3", enc_i(5'd1, 3'd7, 3'd3, 4'd0), 16'd2);

        expect_done("sub_wrap", enc_i(5'd2, 3'd4, 3'd0, 4'd1), 16'hFFFF);
        expect_done("sra_r5", enc_i(5'd7, 3'd5, 3'd4, 4'd4), 16'hFFFF);
        expect_done("srl_r6", enc_i(5'd6, 3'd6, 3'd4, 4'd4), 16'h0FFF);
        expect_done("sll", enc_i(5'd8, 3'd7, 3'd1, 4'd4), 16'h0050);
        expect_done("xor", enc_r(5'd5, 3'd7, 3'd1, 3'd2), 16'h0006);

        run(enc_i(5'd0, 3'd1, 3'd0, 4'd9), r, dc, ec, o2, o3);
        check("op0_err_cyc", ec, 2);
        check("op0_no_done", dc, -1);
        run(enc_i(5'd9, 3'd2, 3'd0, 4'd9), r, dc, ec, o2, o3);
        check("op9_err_cyc", ec, 2);
        check("op9_no_done", dc, -1);
        expect_done("r1_kept", enc_i(5'd1, 3'd7, 3'd1, 4'd0), 16'd5);
        expect_done("r2_kept", enc_i(5'd1, 3'd7, 3'd2, 4'd0), 16'd3);

        expect_done("wr_r0", enc_i(5'd1, 3'd0, 3'd0, 4'd7), 16'd7);
        expect_done("rd_r0", enc_r(5'd4, 3'd7, 3'd0, 3'd0), 16'd0);

        ready_mask = '0;
        done_mask  = '0;
        done_seen  = 0;
        last_res   = 16'h0;
        instr       = enc_i(5'd1, 3'd1, 3'd1, 4'd1);
        instr_valid = 1'b1;
        for (int c = 0; c < 12; c++) begin
            ready_mask[c] = instr_ready;
            done_mask[c]  = done;
            if (done) begin
                done_seen++;
                last_res = result;
            end
            @(negedge clk);
        end
        instr_valid = 1'b0;
        check("b2b_ready_mask", {20'h0, ready_mask}, 32'h111);
        check("b2b_done_mask", {20'h0, done_mask}, 32'h888);
        check("b2b_done_count", done_seen, 3);
        check("b2b_last_res", {16'h0, last_res}, 32'd8);

        instr       = enc_i(5'd1, 3'd2, 3'd1, 4'd2);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("mid_exec_op", {27'h0, alu_op}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("mid_rst_op", {27'h0, alu_op}, 0);
        check("mid_rst_a", {16'h0, alu_a}, 0);
        check("mid_rst_b", {16'h0, alu_b}, 0);
        check("mid_rst_ready", {31'h0, instr_ready}, 1);
        check("mid_rst_result", {16'h0, result}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        done_seen = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done) done_seen++;
        end
        check("post_rst_no_done", done_seen, 0);
        expect_done("post_rst_r1", enc_i(5'd1, 3'd7, 3'd1, 4'd0), 16'd0);
        expect_done("post_rst_r4", enc_r(5'd4, 3'd7, 3'd4, 3'd0), 16'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
